instr_fetch_unit: RTL and testbench

Initiator side of the instruction-memory read interface. Holds the program counter and issues word-addressed read requests to the instruction memory. Captures in-order read responses into a small FIFO and presents fetched instructions with their PCs to decode over a valid/ready handshake. Handles redirects (branch/jump) by flushing the FIFO and discarding any responses still in flight.

---
 rtl/core_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the instruction fetch slice.
// Revision: 1.0
`default_nettype none

package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with flush; push while full is accepted when a pop frees the slot.
// Revision: 1.0
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC generation, credit-limited imem reads, in-order response FIFO and redirect handling.
// Revision: 1.0
`default_nettype none

module instr_fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_L = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAX_L   = CW'(MAX_OUT);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic          err_q;

  logic          redirect_run;
  logic          misaligned;
  logic          rsp_ok;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          issue;
  logic [CW:0]   credit_sum;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_pkt_t    push_pkt;
  fetch_pkt_t    head_pkt;
  logic [31:0]   tag_head;
  logic          fifo_full_unused;
  logic          tag_full_unused;
  logic          tag_empty_unused;
  logic [CW-1:0] tag_count_unused;

  assign redirect_run = redirect_valid && (state_q == ST_RUN);
  assign misaligned   = redirect_run && (redirect_pc[1:0] != 2'b00);

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp_ok   = imem_rvalid && (outstanding != '0);
  assign rsp_drop = rsp_ok && (drop_cnt != '0);
  assign rsp_keep = rsp_ok && (drop_cnt == '0);

  // Credits count dropped-but-pending responses too, so the FIFO can never overflow.
  assign credit_sum = {1'b0, outstanding} + {1'b0, fifo_count};
  assign issue      = !rst && (state_q == ST_RUN) && !redirect_valid &&
                      (credit_sum < DEPTH_L) && (outstanding < MAX_L);

  assign fifo_push = rsp_keep && (state_q == ST_RUN) && !redirect_valid;
  assign fifo_pop  = if_valid && if_ready;
  assign push_pkt  = '{pc: tag_head, instr: imem_rdata};

  assign imem_req     = issue;
  assign imem_addr    = {2'b00, fetch_pc[31:2]};
  assign if_valid     = !rst && (state_q == ST_RUN) && !redirect_valid && !fifo_empty;
  assign if_instr     = if_valid ? head_pkt.instr : '0;
  assign if_pc        = if_valid ? head_pkt.pc : '0;
  assign misalign_err = err_q && !rst;

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && misaligned) state_d = ST_HALT;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      err_q       <= 1'b0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(rsp_ok);
      if (redirect_run) begin
        // Everything still in flight after this edge belongs to the old path.
        drop_cnt <= outstanding - CW'(rsp_ok);
        if (misaligned) err_q    <= 1'b1;
        else            fetch_pc <= redirect_pc;
      end else begin
        if (issue)    fetch_pc <= fetch_pc + 32'd4;
        if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_pkt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_run),
    .push  (fifo_push),
    .din   (push_pkt),
    .pop   (fifo_pop),
    .dout  (head_pkt),
    .full  (fifo_full_unused),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_run),
    .push  (issue),
    .din   (fetch_pc),
    .pop   (rsp_keep),
    .dout  (tag_head),
    .full  (tag_full_unused),
    .empty (tag_empty_unused),
    .count (tag_count_unused)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table plus hand sequences for backpressure, redirect and reset.
// Revision: 1.0
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2),
    .MAX_OUT    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .misalign_err   (misalign_err)
  );

  // Memory model: returns the word address as data after lat cycles, cleared by rst.
  int          lat = 1;
  logic        pv [4] = '{default: 1'b0};
  logic [31:0] pd [4] = '{default: 32'h0};
  int          tb_out = 0;
  int          proto_viol = 0;

  assign imem_rvalid = pv[lat-1];
  assign imem_rdata  = pd[lat-1];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) pv[i] <= 1'b0;
      tb_out <= 0;
    end else begin
      if (imem_rvalid && tb_out == 0) proto_viol <= proto_viol + 1;
      pv[0] <= imem_req;
      pd[0] <= imem_addr;
      for (int i = 1; i < 4; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      tb_out <= tb_out + (imem_req ? 1 : 0) - (imem_rvalid ? 1 : 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    lat = l;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs until the first request and first delivered packet are seen, then checks both.
  task automatic expect_next(input logic [31:0] exp_addr, input logic [31:0] exp_pc, input string name);
    bit          got_req = 0;
    bit          got_pkt = 0;
    logic [31:0] a = '0;
    logic [31:0] p = '0;
    logic [31:0] ins = '0;
    for (int n = 0; n < 40 && !(got_req && got_pkt); n++) begin
      #1;
      if (imem_req && !got_req) begin got_req = 1; a = imem_addr; end
      if (if_valid && if_ready && !got_pkt) begin got_pkt = 1; p = if_pc; ins = if_instr; end
      @(negedge clk);
    end
    chk({name, "_req_seen"}, 32'(got_req), 32'd1);
    chk({name, "_pkt_seen"}, 32'(got_pkt), 32'd1);
    chk({name, "_first_addr"}, a, exp_addr);
    chk({name, "_first_pc"}, p, exp_pc);
    chk({name, "_first_instr"}, ins, {2'b00, exp_pc[31:2]});
  endtask

  typedef struct {
    logic        rst;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int          nreq;
    int          k;
    bit          seen;

    // Straight-line fetch, 1-cycle memory, decode always ready.
    tbl[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 32'h1, 1'b0, 32'h0, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 32'h2, 1'b1, 32'h4, 32'h1};
    tbl[5] = '{1'b0, 1'b1, 32'h3, 1'b0, 32'h0, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 32'h2};
    tbl[7] = '{1'b0, 1'b1, 32'h4, 1'b1, 32'hC, 32'h3};

    lat = 1;
    if_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].rst;
      #1;
      chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
      if (tbl[i].exp_req) chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid || tbl[i].rst) begin
        chk($sformatf("vec%0d_pc", i), if_pc, tbl[i].exp_pc);
        chk($sformatf("vec%0d_instr", i), if_instr, tbl[i].exp_instr);
      end
      if (tbl[i].rst) chk("vec_rst_err", 32'(misalign_err), 32'd0);
      @(negedge clk);
    end

    // Backpressure: only FIFO_DEPTH requests, head held at pc 0, nothing lost on release.
    do_reset(1);
    nreq = 0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (imem_req) nreq++;
      if (if_valid) begin
        seen = 1;
        chk("bp_head_pc", if_pc, 32'h0);
        chk("bp_head_instr", if_instr, 32'h0);
      end
      @(negedge clk);
    end
    chk("bp_req_count", 32'(nreq), 32'd2);
    chk("bp_valid_seen", 32'(seen), 32'd1);
    if_ready = 1'b1;
    k = 0;
    for (int n = 0; n < 40 && k < 4; n++) begin
      #1;
      if (if_valid && if_ready) begin
        chk($sformatf("bp_rel_pc%0d", k), if_pc, 32'(k * 4));
        chk($sformatf("bp_rel_instr%0d", k), if_instr, 32'(k));
        k++;
      end
      @(negedge clk);
    end
    chk("bp_rel_count", 32'(k), 32'd4);

    // Redirect with two requests in flight (3-cycle memory).
    do_reset(3);
    if_ready = 1'b1;
    #1; chk("rd2_issue0", 32'(imem_req), 32'd1); @(negedge clk);
    #1; chk("rd2_issue1", 32'(imem_req), 32'd1); @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    #1;
    chk("rd2_req_blocked", 32'(imem_req), 32'd0);
    chk("rd2_no_rsp_yet", 32'(imem_rvalid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    expect_next(32'h40, 32'h100, "rd2");

    // Redirect coinciding with a kept response and a valid head (2-cycle memory).
    do_reset(2);
    if_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin #1; @(negedge clk); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    chk("rdc_valid_forced_low", 32'(if_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    expect_next(32'h80, 32'h200, "rdc");

    // Misaligned redirect halts until reset.
    do_reset(1);
    if_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin #1; @(negedge clk); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    #1;
    chk("mis_req_same_cycle", 32'(imem_req), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("mis_err_c%0d", c), 32'(misalign_err), 32'd1);
      chk($sformatf("mis_req_c%0d", c), 32'(imem_req), 32'd0);
      chk($sformatf("mis_valid_c%0d", c), 32'(if_valid), 32'd0);
      @(negedge clk);
    end
    do_reset(1);
    if_ready = 1'b1;
    #1;
    chk("mis_err_cleared", 32'(misalign_err), 32'd0);
    @(negedge clk);
    do_reset(1);
    if_ready = 1'b1;
    expect_next(32'h0, 32'h0, "mis_restart");

    // Reset mid-stream with responses pending and FIFO occupied.
    do_reset(2);
    for (int c = 0; c < 4; c++) begin #1; @(negedge clk); end
    rst = 1'b1;
    #1;
    chk("mrst_req", 32'(imem_req), 32'd0);
    chk("mrst_valid", 32'(if_valid), 32'd0);
    chk("mrst_pc", if_pc, 32'h0);
    chk("mrst_instr", if_instr, 32'h0);
    chk("mrst_err", 32'(misalign_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    if_ready = 1'b1;
    expect_next(32'h0, 32'h0, "mrst_restart");

    chk("protocol_rvalid_without_req", 32'(proto_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
